// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types: shared types for the two-level branch predictor and its
// resolve-side unit.
//   lc3b_word       16-bit machine word / PC
//   lc3b_bht_ind    3-bit BHT index (pc[3:1])
//   lc3b_bht_out    BHT history entry (BRQ_HIST_W bits)
//   lc3b_pht_ind    PHT index {pc[3:1], history}
//   lc3b_ctr2       2-bit saturating PHT counter
//   lc3b_brq_entry  checkpoint stored per in-flight predicted branch
// ctr_update() gives the next saturating counter value for an outcome.
// -----------------------------------------------------------------------------
package lc3b_types;

    localparam int BRQ_HIST_W = 4;

    typedef logic [15:0]             lc3b_word;
    typedef logic [2:0]              lc3b_bht_ind;
    typedef logic [BRQ_HIST_W-1:0]   lc3b_bht_out;
    typedef logic [2+BRQ_HIST_W:0]   lc3b_pht_ind;
    typedef logic [1:0]              lc3b_ctr2;

    typedef struct packed {
        lc3b_word    pc;
        lc3b_bht_out hist;
        lc3b_ctr2    ctr;
        logic        taken;
        lc3b_word    target;
    } lc3b_brq_entry;

    // Saturating 2-bit counter: step toward 3 on taken, toward 0 otherwise.
    function automatic lc3b_ctr2 ctr_update(input lc3b_ctr2 ctr, input logic taken);
        lc3b_ctr2 r;
        r = ctr;
        if (taken) begin
            if (ctr != 2'd3) r = ctr + 2'd1;
        end else begin
            if (ctr != 2'd0) r = ctr - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_if: bundle of all non-clock signals of the branch
// resolve unit.
//   master modport: fetch/execute side (drives pred_* and res_*, observes the
//                   write-back, redirect and status outputs)
//   slave modport : the branch_resolve_unit itself
// Optional macro BRU_STATS_EN adds stat_branches / stat_mispredicts.
// -----------------------------------------------------------------------------
interface branch_resolve_unit_if;
    import lc3b_types::*;

    // Prediction checkpoint push
    logic        pred_valid;
    logic        pred_ready;
    lc3b_word    pred_pc;
    lc3b_bht_out pred_hist;
    lc3b_ctr2    pred_ctr;
    logic        pred_taken;
    lc3b_word    pred_target;
    // Resolution of the oldest branch
    logic        res_valid;
    logic        res_taken;
    lc3b_word    res_target;
    // Predictor write-back
    logic        bht_we;
    lc3b_bht_ind bht_idx;
    lc3b_bht_out bht_wdata;
    logic        pht_we;
    lc3b_pht_ind pht_idx;
    lc3b_ctr2    pht_wdata;
    // Redirect / status
    logic        mispredict;
    lc3b_word    redirect_pc;
    logic        res_underflow;
`ifdef BRU_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    modport master (
`ifdef BRU_STATS_EN
        input  stat_branches, stat_mispredicts,
`endif
        output pred_valid, pred_pc, pred_hist, pred_ctr, pred_taken, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, bht_we, bht_idx, bht_wdata, pht_we, pht_idx, pht_wdata,
        input  mispredict, redirect_pc, res_underflow
    );

    modport slave (
`ifdef BRU_STATS_EN
        output stat_branches, stat_mispredicts,
`endif
        input  pred_valid, pred_pc, pred_hist, pred_ctr, pred_taken, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, bht_we, bht_idx, bht_wdata, pht_we, pht_idx, pht_wdata,
        output mispredict, redirect_pc, res_underflow
    );

endinterface

// File: rtl/branch_resolve_unit_brq.sv
// -----------------------------------------------------------------------------
// brq_fifo: DEPTH-entry circular checkpoint queue.
//   clk, reset_n : clock, asynchronous active-low reset (pointers only)
//   push, wdata  : enqueue at tail (ignored when full unless popping too)
//   pop          : dequeue head (ignored when empty)
//   clear        : empty the queue; wins over push and pop
//   full, empty  : occupancy flags
//   head         : oldest entry, combinational read so the caller can compare
//                  it in the same cycle it is popped
// DEPTH must be a power of two so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module brq_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  lc3b_brq_entry wdata,
    input  logic          pop,
    input  logic          clear,
    output logic          full,
    output logic          empty,
    output lc3b_brq_entry head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lc3b_brq_entry    mem [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[head_reg];

    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && !clear && (!full || pop_ok);
    assign pop_ok  = pop && !clear && !empty;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (clear) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push_ok) tail_next = tail_reg + PTR_W'(1);
            if (pop_ok)  head_next = head_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail_reg] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit: resolve side of the two-level branch predictor.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : branch_resolve_unit_if.slave
//              pred_*  checkpoint push from fetch (pred_ready = slot free)
//              res_*   actual outcome of the oldest branch, pops the queue
//              bht_*/pht_* registered predictor write-back (1 cycle later)
//              mispredict/redirect_pc registered redirect pulse
//              res_underflow sticky flag: resolve seen with empty queue
// Optional macro BRU_STATS_EN: adds saturating stat_branches (every res_valid)
// and stat_mispredicts (every mispredict pulse) counters, visible in the same
// cycle as the corresponding write-back / pulse.
// The cycle in which mispredict is high is the squash cycle: the queue is
// cleared, any push is dropped and any resolve counts as underflow.
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import lc3b_types::*;
#(
    parameter int DEPTH  = 8,
    parameter int HIST_W = BRQ_HIST_W
) (
    input  logic clk,
    input  logic reset_n,
    branch_resolve_unit_if.slave bus
);

    lc3b_brq_entry pred_entry;
    lc3b_brq_entry head_entry;
    logic          full;
    logic          empty;
    logic          squash;
    logic          push;
    logic          pop;
    logic          underflow_ev;
    logic          mis_now;

    logic          bht_we_reg,      bht_we_next;
    lc3b_bht_ind   bht_idx_reg,     bht_idx_next;
    lc3b_bht_out   bht_wdata_reg,   bht_wdata_next;
    logic          pht_we_reg,      pht_we_next;
    lc3b_pht_ind   pht_idx_reg,     pht_idx_next;
    lc3b_ctr2      pht_wdata_reg,   pht_wdata_next;
    logic          mispredict_reg,  mispredict_next;
    lc3b_word      redirect_pc_reg, redirect_pc_next;
    logic          underflow_reg,   underflow_next;

    assign squash = mispredict_reg;

    assign pred_entry = '{pc:     bus.pred_pc,
                          hist:   bus.pred_hist,
                          ctr:    bus.pred_ctr,
                          taken:  bus.pred_taken,
                          target: bus.pred_target};

    // Ready is held high in the squash cycle so fetch never stalls on a
    // queue that is about to be emptied.
    assign bus.pred_ready = !full || bus.res_valid || squash;
    assign push           = bus.pred_valid && bus.pred_ready && !squash;
    // A resolve in the squash cycle sees the already-cleared queue.
    assign pop            = bus.res_valid && !empty && !squash;
    assign underflow_ev   = bus.res_valid && (empty || squash);

    brq_fifo #(
        .DEPTH (DEPTH)
    ) u_brq_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (pred_entry),
        .pop     (pop),
        .clear   (squash),
        .full    (full),
        .empty   (empty),
        .head    (head_entry)
    );

    assign mis_now = (bus.res_taken != head_entry.taken) ||
                     (bus.res_taken && (bus.res_target != head_entry.target));

    always_comb begin
        bht_we_next      = 1'b0;
        bht_idx_next     = '0;
        bht_wdata_next   = '0;
        pht_we_next      = 1'b0;
        pht_idx_next     = '0;
        pht_wdata_next   = '0;
        mispredict_next  = 1'b0;
        redirect_pc_next = '0;
        underflow_next   = underflow_reg || underflow_ev;
        if (pop) begin
            bht_we_next    = 1'b1;
            bht_idx_next   = head_entry.pc[3:1];
            bht_wdata_next = {head_entry.hist[HIST_W-2:0], bus.res_taken};
            pht_we_next    = 1'b1;
            pht_idx_next   = {head_entry.pc[3:1], head_entry.hist};
            pht_wdata_next = ctr_update(head_entry.ctr, bus.res_taken);
            if (mis_now) begin
                mispredict_next  = 1'b1;
                redirect_pc_next = bus.res_taken ? bus.res_target
                                                 : head_entry.pc + 16'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bht_we_reg      <= 1'b0;
            bht_idx_reg     <= '0;
            bht_wdata_reg   <= '0;
            pht_we_reg      <= 1'b0;
            pht_idx_reg     <= '0;
            pht_wdata_reg   <= '0;
            mispredict_reg  <= 1'b0;
            redirect_pc_reg <= '0;
            underflow_reg   <= 1'b0;
        end else begin
            bht_we_reg      <= bht_we_next;
            bht_idx_reg     <= bht_idx_next;
            bht_wdata_reg   <= bht_wdata_next;
            pht_we_reg      <= pht_we_next;
            pht_idx_reg     <= pht_idx_next;
            pht_wdata_reg   <= pht_wdata_next;
            mispredict_reg  <= mispredict_next;
            redirect_pc_reg <= redirect_pc_next;
            underflow_reg   <= underflow_next;
        end
    end

    assign bus.bht_we        = bht_we_reg;
    assign bus.bht_idx       = bht_idx_reg;
    assign bus.bht_wdata     = bht_wdata_reg;
    assign bus.pht_we        = pht_we_reg;
    assign bus.pht_idx       = pht_idx_reg;
    assign bus.pht_wdata     = pht_wdata_reg;
    assign bus.mispredict    = mispredict_reg;
    assign bus.redirect_pc   = redirect_pc_reg;
    assign bus.res_underflow = underflow_reg;

`ifdef BRU_STATS_EN
    logic [15:0] stat_branches_reg;
    logic [15:0] stat_mispredicts_reg;

    // Counted at the edge that registers the event so each counter moves in
    // the same cycle the write-back / pulse becomes visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches_reg    <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            if (bus.res_valid && (stat_branches_reg != 16'hFFFF))
                stat_branches_reg <= stat_branches_reg + 16'd1;
            if (mispredict_next && (stat_mispredicts_reg != 16'hFFFF))
                stat_mispredicts_reg <= stat_mispredicts_reg + 16'd1;
        end
    end

    assign bus.stat_branches    = stat_branches_reg;
    assign bus.stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int DEPTH = 8;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  hist;
        logic [1:0]  ctr;
        logic        taken;
        logic [15:0] target;
    } ent_t;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_resolve_unit_if bus();

    branch_resolve_unit #(
        .DEPTH  (DEPTH),
        .HIST_W (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: queue of pending checkpoints plus the outputs
    // expected after the most recent edge.
    ent_t        mq[$];
    logic        m_bwe, m_pwe, m_mis, m_uf;
    logic [2:0]  m_bidx;
    logic [3:0]  m_bwd;
    logic [6:0]  m_pidx;
    logic [1:0]  m_pwd;
    logic [15:0] m_redir;
    int          m_sb, m_sm;
    ent_t        nil;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [15:0] pc, input logic [3:0] h,
                                input logic [1:0] c, input logic t, input logic [15:0] tg);
        ent_t e;
        e.pc = pc; e.hist = h; e.ctr = c; e.taken = t; e.target = tg;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk(16'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 16'($urandom));
    endfunction

    task automatic model_clear();
        mq.delete();
        m_bwe = 0; m_pwe = 0; m_mis = 0; m_uf = 0;
        m_bidx = 0; m_bwd = 0; m_pidx = 0; m_pwd = 0; m_redir = 0;
        m_sb = 0; m_sm = 0;
    endtask

    // Entered and left at a falling edge; one clock cycle per call.
    task automatic step(input logic pv, input ent_t pe, input logic rv,
                        input logic rt, input logic [15:0] rtg);
        logic squash, ready;
        ent_t e;
        int c;
        bus.pred_valid  = pv;
        bus.pred_pc     = pe.pc;
        bus.pred_hist   = pe.hist;
        bus.pred_ctr    = pe.ctr;
        bus.pred_taken  = pe.taken;
        bus.pred_target = pe.target;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        bus.res_target  = rtg;
        #1;
        squash = m_mis;
        ready  = (mq.size() < DEPTH) || rv || squash;
        check_eq("pred_ready", 32'(bus.pred_ready), 32'(ready));
        @(posedge clk);
        m_bwe = 0; m_pwe = 0; m_mis = 0;
        if (rv && m_sb < 65535) m_sb++;
        if (squash) begin
            mq.delete();
            if (rv) m_uf = 1;
        end else begin
            if (rv) begin
                if (mq.size() == 0) begin
                    m_uf = 1;
                end else begin
                    e = mq.pop_front();
                    c = int'(e.ctr);
                    m_bwe  = 1; m_pwe = 1;
                    m_bidx = e.pc[3:1];
                    m_bwd  = {e.hist[2:0], rt};
                    m_pidx = {e.pc[3:1], e.hist};
                    m_pwd  = rt ? 2'((c == 3) ? 3 : c + 1) : 2'((c == 0) ? 0 : c - 1);
                    m_mis  = (rt != e.taken) || (rt && rtg != e.target);
                    m_redir = rt ? rtg : e.pc + 16'd2;
                    if (m_mis && m_sm < 65535) m_sm++;
                end
            end
            if (pv && ready) mq.push_back(pe);
        end
        #1;
        check_eq("bht_we", 32'(bus.bht_we), 32'(m_bwe));
        check_eq("pht_we", 32'(bus.pht_we), 32'(m_pwe));
        check_eq("mispredict", 32'(bus.mispredict), 32'(m_mis));
        check_eq("res_underflow", 32'(bus.res_underflow), 32'(m_uf));
        if (m_bwe) begin
            check_eq("bht_idx", 32'(bus.bht_idx), 32'(m_bidx));
            check_eq("bht_wdata", 32'(bus.bht_wdata), 32'(m_bwd));
            check_eq("pht_idx", 32'(bus.pht_idx), 32'(m_pidx));
            check_eq("pht_wdata", 32'(bus.pht_wdata), 32'(m_pwd));
        end
        if (m_mis) check_eq("redirect_pc", 32'(bus.redirect_pc), 32'(m_redir));
`ifdef BRU_STATS_EN
        check_eq("stat_branches", 32'(bus.stat_branches), 32'(m_sb[15:0]));
        check_eq("stat_mispredicts", 32'(bus.stat_mispredicts), 32'(m_sm[15:0]));
`endif
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; entered/left at a falling edge.
    task automatic do_reset();
        bus.pred_valid = 0; bus.res_valid = 0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
        check_eq("rst_bht_we", 32'(bus.bht_we), 32'd0);
        check_eq("rst_pht_we", 32'(bus.pht_we), 32'd0);
        check_eq("rst_mispredict", 32'(bus.mispredict), 32'd0);
        check_eq("rst_underflow", 32'(bus.res_underflow), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic resolve_front_correct(input logic pv, input ent_t pe);
        step(pv, pe, 1'b1, mq[0].taken, mq[0].target);
    endtask

    initial begin
        logic        pv, rv, rt;
        logic [15:0] rtg;
        nil = mk(16'h0, 4'h0, 2'h0, 1'b0, 16'h0);
        reset_n = 1'b1;
        bus.pred_valid = 0; bus.pred_pc = 0; bus.pred_hist = 0; bus.pred_ctr = 0;
        bus.pred_taken = 0; bus.pred_target = 0;
        bus.res_valid = 0; bus.res_taken = 0; bus.res_target = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Reset mid-stream with three checkpoints queued.
        for (int i = 0; i < 3; i++) step(1'b1, rnd_ent(), 1'b0, 1'b0, 16'h0);
        do_reset();
        step(1'b0, nil, 1'b1, 1'b1, 16'h1234);
        check_eq("rst_then_underflow", 32'(bus.res_underflow), 32'd1);

        // Correct prediction.
        do_reset();
        step(1'b1, mk(16'h0106, 4'b1010, 2'd2, 1'b1, 16'h0200), 1'b0, 1'b0, 16'h0);
        step(1'b0, nil, 1'b1, 1'b1, 16'h0200);
        check_eq("cp_bht_idx", 32'(bus.bht_idx), 32'd3);
        check_eq("cp_bht_wdata", 32'(bus.bht_wdata), 32'b0101);
        check_eq("cp_pht_idx", 32'(bus.pht_idx), 32'b0111010);
        check_eq("cp_pht_wdata", 32'(bus.pht_wdata), 32'd3);
        check_eq("cp_mispredict", 32'(bus.mispredict), 32'd0);

        // Direction mispredict followed by a squash collision.
        step(1'b1, mk(16'h0110, 4'h3, 2'd0, 1'b1, 16'h0400), 1'b0, 1'b0, 16'h0);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 16'h0);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 16'h0);
        step(1'b0, nil, 1'b1, 1'b0, 16'h0);
        check_eq("dm_mispredict", 32'(bus.mispredict), 32'd1);
        check_eq("dm_redirect_pc", 32'(bus.redirect_pc), 32'h0112);
        check_eq("dm_pht_wdata", 32'(bus.pht_wdata), 32'd0);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 16'h0);   // squash cycle, push dropped
        step(1'b0, nil, 1'b1, 1'b1, 16'h0);
        check_eq("sq_underflow", 32'(bus.res_underflow), 32'd1);

        // Target mispredict, and not-taken redirect wrapping at 16'hFFFE.
        do_reset();
        step(1'b1, mk(16'h0120, 4'h5, 2'd3, 1'b1, 16'h0300), 1'b0, 1'b0, 16'h0);
        step(1'b0, nil, 1'b1, 1'b1, 16'h0310);
        check_eq("tm_mispredict", 32'(bus.mispredict), 32'd1);
        check_eq("tm_redirect_pc", 32'(bus.redirect_pc), 32'h0310);
        step(1'b0, nil, 1'b0, 1'b0, 16'h0);
        step(1'b1, mk(16'hFFFE, 4'h9, 2'd2, 1'b1, 16'h0010), 1'b0, 1'b0, 16'h0);
        step(1'b0, nil, 1'b1, 1'b0, 16'h0);
        check_eq("wrap_redirect_pc", 32'(bus.redirect_pc), 32'h0000);
        check_eq("wrap_pht_wdata", 32'(bus.pht_wdata), 32'd1);

        // Full queue, push+resolve while full, pointers wrapped twice.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk(16'(i * 2), 4'(i), 2'(i), 1'b0, 16'h0), 1'b0, 1'b0, 16'h0);
        step(1'b1, rnd_ent(), 1'b0, 1'b0, 16'h0);   // held push ignored
        check_eq("full_pred_ready", 32'(bus.pred_ready), 32'd0);
        for (int i = 0; i < 2 * DEPTH + 3; i++)
            resolve_front_correct(1'b1, mk(16'(i * 6 + 2), 4'(i + 5), 2'($urandom), 1'($urandom), 16'($urandom)));
        check_eq("full_count", 32'(mq.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) resolve_front_correct(1'b0, nil);
        step(1'b0, nil, 1'b0, 1'b0, 16'h0);
        check_eq("drain_no_underflow", 32'(bus.res_underflow), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            pv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 45);
            if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
                rt  = mq[0].taken;
                rtg = ($urandom_range(0, 7) == 0) ? 16'($urandom) : mq[0].target;
            end else begin
                rt  = 1'($urandom);
                rtg = 16'($urandom);
            end
            step(pv, rnd_ent(), rv, rt, rtg);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
